pixel_classifier: RTL

PIXEL_CLASSIFIER -- requirements
Module: pixel_classifier

---
 rtl/pixel_classifier.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/pixel_classifier.sv
// pixel_classifier: two-stage pixel classifier for a scrolling music-staff display.
// Each pixel is classified as note (00), staff (01), text (10) or background (11).
// Note positions come from a 32-entry column table that can be written at run time.
// Optional feature macro SCROLL_EN: frame_start advances a 5-bit column offset.
module pixel_classifier #(
   parameter int unsigned COL_SHIFT = 4,
   parameter int unsigned STAFF_TOP = 160,
   parameter int unsigned STAFF_GAP = 16,
   parameter int unsigned TEXT_ROWS = 32
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       in_valid,
   input  logic [9:0] x,
   input  logic [8:0] y,
   input  logic       text_bit,
   input  logic       frame_start,
   input  logic       note_wr_en,
   input  logic [4:0] note_wr_col,
   input  logic [3:0] note_wr_pitch,
   input  logic [1:0] note_wr_instr,
   input  logic       note_wr_clear,
   input  logic       clear_all,
   output logic [1:0] pixel_type,
   output logic [1:0] instrument_type,
   output logic       out_valid
);

   localparam int unsigned NUM_COLS   = 32;
   localparam int unsigned NUM_LINES  = 5;
   localparam int unsigned YC_BASE    = STAFF_TOP + 4 * STAFF_GAP;
   localparam int unsigned HALF_GAP   = STAFF_GAP / 2;
   localparam logic [1:0]  PT_NOTE    = 2'b00;
   localparam logic [1:0]  PT_STAFF   = 2'b01;
   localparam logic [1:0]  PT_TEXT    = 2'b10;
   localparam logic [1:0]  PT_BG      = 2'b11;

   typedef struct packed {
      logic       valid;
      logic [3:0] pitch;
      logic [1:0] instr;
   } note_entry_t;

   note_entry_t table_q [NUM_COLS];
   note_entry_t table_d [NUM_COLS];

   logic [4:0] offset_c;

`ifdef SCROLL_EN
   logic [4:0] offset_q;
   logic [4:0] offset_d;

   // Advance the scroll offset once per frame; 5-bit wrap 31 -> 0 is natural.
   always_comb begin
      offset_d = offset_q;
      if (frame_start) begin
         offset_d = offset_q + 5'd1;
      end
   end

   // Offset register; frame_start during reset is dropped by reset priority.
   always_ff @(posedge clk) begin
      if (reset) begin
         offset_q <= 5'd0;
      end else begin
         offset_q <= offset_d;
      end
   end

   assign offset_c = offset_q;
`else
   logic unused_frame_start;
   assign unused_frame_start = frame_start;
   assign offset_c           = 5'd0;
`endif

   // Note table update: clear_all overrides any single-entry write.
   always_comb begin
      table_d = table_q;
      if (clear_all) begin
         for (int i = 0; i < NUM_COLS; i++) begin
            table_d[i].valid = 1'b0;
         end
      end else if (note_wr_en) begin
         if (note_wr_clear) begin
            table_d[note_wr_col].valid = 1'b0;
         end else begin
            table_d[note_wr_col] = '{valid: 1'b1, pitch: note_wr_pitch, instr: note_wr_instr};
         end
      end
   end

   // Note table storage; writes during reset are ignored.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_COLS; i++) begin
            table_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_COLS; i++) begin
            table_q[i] <= table_d[i];
         end
      end
   end

   // Stage 1 signals: only the x bits the classifier needs are kept.
   logic        s1_valid_q, s1_valid_d;
   logic [3:0]  s1_x_lo_q, s1_x_lo_d;
   logic        s1_x_hi_q, s1_x_hi_d;
   logic        s1_oob_q, s1_oob_d;
   logic [8:0]  s1_y_q, s1_y_d;
   logic        s1_text_q, s1_text_d;
   note_entry_t s1_entry_q, s1_entry_d;
   logic [9:0]  col_full_c;
   logic [4:0]  lookup_col_c;

   // Stage 1: column lookup reads the table before this cycle's write lands.
   always_comb begin
      col_full_c   = x >> COL_SHIFT;
      lookup_col_c = 5'(col_full_c) + offset_c;
      s1_valid_d   = in_valid;
      s1_x_lo_d    = x[3:0];
      s1_x_hi_d    = x[9];
      s1_oob_d     = (col_full_c >= 10'(NUM_COLS));
      s1_y_d       = y;
      s1_text_d    = text_bit;
      s1_entry_d   = table_q[lookup_col_c];
   end

   // Stage 1 pipeline registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid_q <= 1'b0;
         s1_x_lo_q  <= 4'd0;
         s1_x_hi_q  <= 1'b0;
         s1_oob_q   <= 1'b0;
         s1_y_q     <= 9'd0;
         s1_text_q  <= 1'b0;
         s1_entry_q <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_x_lo_q  <= s1_x_lo_d;
         s1_x_hi_q  <= s1_x_hi_d;
         s1_oob_q   <= s1_oob_d;
         s1_y_q     <= s1_y_d;
         s1_text_q  <= s1_text_d;
         s1_entry_q <= s1_entry_d;
      end
   end

   logic [1:0] pixel_type_q, pixel_type_d;
   logic [1:0] instrument_type_q, instrument_type_d;
   logic       out_valid_q, out_valid_d;
   logic [9:0] y_ext_c;
   logic [9:0] yc_c;
   logic       on_line_c;
   logic       is_note_c;
   logic       is_staff_c;
   logic       is_text_c;

   // Stage 2: classify with note > staff > text > background priority.
   always_comb begin
      y_ext_c   = {1'b0, s1_y_q};
      yc_c      = 10'(YC_BASE) - 10'(s1_entry_q.pitch) * 10'(HALF_GAP);
      on_line_c = 1'b0;
      for (int k = 0; k < NUM_LINES; k++) begin
         if (y_ext_c == 10'(STAFF_TOP + k * STAFF_GAP)) begin
            on_line_c = 1'b1;
         end
      end
      is_note_c  = s1_entry_q.valid && !s1_oob_q
                && (s1_x_lo_q >= 4'd4) && (s1_x_lo_q <= 4'd11)
                && (y_ext_c + 10'd3 >= yc_c) && (y_ext_c <= yc_c + 10'd3);
      is_staff_c = on_line_c && !s1_x_hi_q;
      is_text_c  = (s1_y_q < 9'(TEXT_ROWS)) && s1_text_q;

      pixel_type_d      = PT_BG;
      instrument_type_d = 2'b00;
      out_valid_d       = s1_valid_q;
      if (s1_valid_q) begin
         if (is_note_c) begin
            pixel_type_d      = PT_NOTE;
            instrument_type_d = s1_entry_q.instr;
         end else if (is_staff_c) begin
            pixel_type_d = PT_STAFF;
         end else if (is_text_c) begin
            pixel_type_d = PT_TEXT;
         end
      end
   end

   // Stage 2 output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         pixel_type_q      <= PT_BG;
         instrument_type_q <= 2'b00;
         out_valid_q       <= 1'b0;
      end else begin
         pixel_type_q      <= pixel_type_d;
         instrument_type_q <= instrument_type_d;
         out_valid_q       <= out_valid_d;
      end
   end

   assign pixel_type      = pixel_type_q;
   assign instrument_type = instrument_type_q;
   assign out_valid       = out_valid_q;

endmodule
